dllp_acknak_sched: RTL and testbench

- Schedules Ack and Nak DLLP transmission for the data link layer receive path.
- Consumes per-TLP sequence check results (sequence number, valid, ack/nak) from the DLLP receive block.
- Tracks the last good sequence number, the NAK_SCHEDULED condition and the AckNak latency timer.
- Emits single-beat Ack/Nak DLLP bodies on an AXI-Stream master toward the DLLP transmit/phy path; CRC16 and framing are added downstream.

---
 rtl/dllp_acknak_sched.sv | 204 ++++++++++++++++++++
 tb/tb_dllp_acknak_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dllp_acknak_sched.sv
// dllp_acknak_sched: Ack/Nak DLLP scheduler for the data link layer receive path.
// Tracks the last good sequence number, NAK_SCHEDULED and the AckNak latency timer,
// and emits single-beat Ack/Nak DLLP bodies on an AXI-Stream master.
// Optional feature macro: DLLP_ACK_COALESCE_EN (Ack after ACK_COALESCE good TLPs).
module dllp_acknak_sched #(
    parameter int DATA_WIDTH   = 32,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 4,
    parameter int ACK_LATENCY  = 255,
    parameter int ACK_COALESCE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            link_status_i,
    input  logic [11:0]           seq_num_i,
    input  logic                  seq_num_vld_i,
    input  logic                  seq_num_acknack_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep_o,
    output logic                  m_axis_tvalid_o,
    output logic                  m_axis_tlast_o,
    output logic [USER_WIDTH-1:0] m_axis_tuser_o,
    input  logic                  m_axis_tready_i,
    output logic                  ack_pending_o,
    output logic                  nak_scheduled_o,
    output logic [11:0]           last_ack_seq_o
);

    localparam int TIMER_W = $clog2(ACK_LATENCY);
    // Request fires when the timer steps onto ACK_LATENCY-1, so tvalid lands ACK_LATENCY
    // cycles after the first good strobe.
    localparam logic [TIMER_W-1:0] TIMER_REQ = TIMER_W'(ACK_LATENCY - 2);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(ACK_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, SEND_ACK, SEND_NAK} state_t;

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   tdata_reg, tdata_next;
    logic [KEEP_WIDTH-1:0]   tkeep_reg, tkeep_next;
    logic                    tvalid_reg, tvalid_next;
    logic                    tlast_reg, tlast_next;
    logic [11:0]             last_ack_seq_reg, last_ack_seq_next;
    logic                    ack_pending_reg, ack_pending_next;
    logic                    nak_scheduled_reg, nak_scheduled_next;
    logic                    nak_req_reg, nak_req_next;
    logic [TIMER_W-1:0]      timer_reg, timer_next;
    logic                    link_up, good_stb, bad_stb, handshake;
    logic                    nak_req_now, ack_req;
    logic [11:0]             sent_seq;
`ifdef DLLP_ACK_COALESCE_EN
    localparam int CNT_W = $clog2(ACK_COALESCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_COALESCE);
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
`endif

    assign link_up     = (link_status_i == 2'b11);
    assign good_stb    = link_up & seq_num_vld_i & seq_num_acknack_i;
    assign bad_stb     = link_up & seq_num_vld_i & ~seq_num_acknack_i;
    assign handshake   = tvalid_reg & m_axis_tready_i;
    assign nak_req_now = nak_req_reg | (bad_stb & ~nak_scheduled_reg);
    assign sent_seq    = {tdata_reg[19:16], tdata_reg[31:24]};
`ifdef DLLP_ACK_COALESCE_EN
    assign ack_req = ack_pending_reg & ((timer_reg >= TIMER_REQ) | (cnt_reg >= CNT_MAX));
`else
    assign ack_req = ack_pending_reg & (timer_reg >= TIMER_REQ);
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic: Nak beats Ack; link down forces IDLE
    always_comb begin
        state_next = state_reg;
        if (!link_up) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (nak_req_now)  state_next = SEND_NAK;
                    else if (ack_req) state_next = SEND_ACK;
                end
                SEND_ACK, SEND_NAK: if (handshake) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Bookkeeping: handshake clears first, then the current strobe is applied on top
    always_comb begin
        last_ack_seq_next  = last_ack_seq_reg;
        ack_pending_next   = ack_pending_reg;
        nak_scheduled_next = nak_scheduled_reg;
        nak_req_next       = (state_reg == IDLE) ? 1'b0 : nak_req_now;
        timer_next         = timer_reg;
`ifdef DLLP_ACK_COALESCE_EN
        cnt_next           = cnt_reg;
`endif
        if (state_reg == IDLE && ack_pending_reg && timer_reg < TIMER_MAX)
            timer_next = timer_reg + 1'b1;
        if (handshake && state_reg == SEND_ACK) begin
            // A newer good TLP during the send keeps the Ack pending and restarts the wait
            if (last_ack_seq_reg == sent_seq) ack_pending_next = 1'b0;
            timer_next = '0;
`ifdef DLLP_ACK_COALESCE_EN
            cnt_next   = '0;
`endif
        end
        if (handshake && state_reg == SEND_NAK) begin
            ack_pending_next = 1'b0;
            timer_next       = '0;
`ifdef DLLP_ACK_COALESCE_EN
            cnt_next         = '0;
`endif
        end
        if (good_stb) begin
            last_ack_seq_next  = seq_num_i;
            ack_pending_next   = 1'b1;
            nak_scheduled_next = 1'b0;
`ifdef DLLP_ACK_COALESCE_EN
            if (cnt_next < CNT_MAX) cnt_next = cnt_next + 1'b1;
`endif
        end
        if (bad_stb && !nak_scheduled_reg) nak_scheduled_next = 1'b1;
        if (!link_up) begin
            last_ack_seq_next  = 12'hFFF;
            ack_pending_next   = 1'b0;
            nak_scheduled_next = 1'b0;
            nak_req_next       = 1'b0;
            timer_next         = '0;
`ifdef DLLP_ACK_COALESCE_EN
            cnt_next           = '0;
`endif
        end
    end

    // Output logic: capture the DLLP on entry to a SEND state, drop it on handshake
    always_comb begin
        tdata_next  = tdata_reg;
        tkeep_next  = tkeep_reg;
        tvalid_next = tvalid_reg;
        tlast_next  = tlast_reg;
        if (!link_up) begin
            tdata_next  = '0;
            tkeep_next  = '0;
            tvalid_next = 1'b0;
            tlast_next  = 1'b0;
        end else if (state_reg == IDLE && state_next != IDLE) begin
            tdata_next  = {last_ack_seq_next[7:0], 4'h0, last_ack_seq_next[11:8], 8'h00,
                           (state_next == SEND_NAK) ? 8'h10 : 8'h00};
            tkeep_next  = '1;
            tvalid_next = 1'b1;
            tlast_next  = 1'b1;
        end else if (handshake) begin
            tdata_next  = '0;
            tkeep_next  = '0;
            tvalid_next = 1'b0;
            tlast_next  = 1'b0;
        end
    end

    // Registered outputs and link-layer bookkeeping
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tdata_reg         <= '0;
            tkeep_reg         <= '0;
            tvalid_reg        <= 1'b0;
            tlast_reg         <= 1'b0;
            last_ack_seq_reg  <= 12'hFFF;
            ack_pending_reg   <= 1'b0;
            nak_scheduled_reg <= 1'b0;
            nak_req_reg       <= 1'b0;
            timer_reg         <= '0;
`ifdef DLLP_ACK_COALESCE_EN
            cnt_reg           <= '0;
`endif
        end else begin
            tdata_reg         <= tdata_next;
            tkeep_reg         <= tkeep_next;
            tvalid_reg        <= tvalid_next;
            tlast_reg         <= tlast_next;
            last_ack_seq_reg  <= last_ack_seq_next;
            ack_pending_reg   <= ack_pending_next;
            nak_scheduled_reg <= nak_scheduled_next;
            nak_req_reg       <= nak_req_next;
            timer_reg         <= timer_next;
`ifdef DLLP_ACK_COALESCE_EN
            cnt_reg           <= cnt_next;
`endif
        end
    end

    assign m_axis_tdata_o  = tdata_reg;
    assign m_axis_tkeep_o  = tkeep_reg;
    assign m_axis_tvalid_o = tvalid_reg;
    assign m_axis_tlast_o  = tlast_reg;
    assign m_axis_tuser_o  = '0;
    assign ack_pending_o   = ack_pending_reg;
    assign nak_scheduled_o = nak_scheduled_reg;
    assign last_ack_seq_o  = last_ack_seq_reg;

endmodule

// File: tb/tb_dllp_acknak_sched.sv
// Directed testbench for dllp_acknak_sched (default ACK_LATENCY=255, ACK_COALESCE=4).
module tb_dllp_acknak_sched;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [1:0]  link_status_i = 2'b00;
    logic [11:0] seq_num_i = '0;
    logic        seq_num_vld_i = 1'b0;
    logic        seq_num_acknack_i = 1'b0;
    logic [31:0] m_axis_tdata_o;
    logic [3:0]  m_axis_tkeep_o;
    logic        m_axis_tvalid_o;
    logic        m_axis_tlast_o;
    logic [3:0]  m_axis_tuser_o;
    logic        m_axis_tready_i = 1'b0;
    logic        ack_pending_o;
    logic        nak_scheduled_o;
    logic [11:0] last_ack_seq_o;

    int n_cmp = 0;
    int n_err = 0;
    int waited;

    dllp_acknak_sched dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .link_status_i     (link_status_i),
        .seq_num_i         (seq_num_i),
        .seq_num_vld_i     (seq_num_vld_i),
        .seq_num_acknack_i (seq_num_acknack_i),
        .m_axis_tdata_o    (m_axis_tdata_o),
        .m_axis_tkeep_o    (m_axis_tkeep_o),
        .m_axis_tvalid_o   (m_axis_tvalid_o),
        .m_axis_tlast_o    (m_axis_tlast_o),
        .m_axis_tuser_o    (m_axis_tuser_o),
        .m_axis_tready_i   (m_axis_tready_i),
        .ack_pending_o     (ack_pending_o),
        .nak_scheduled_o   (nak_scheduled_o),
        .last_ack_seq_o    (last_ack_seq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-24s observed %h", tag, obs);
    endtask

    task automatic strobe(input logic [11:0] seq, input logic ack);
        seq_num_i         = seq;
        seq_num_acknack_i = ack;
        seq_num_vld_i     = 1'b1;
        tick();
        seq_num_vld_i     = 1'b0;
    endtask

    // Bounded wait for tvalid; an expired bound shows up as a failed check
    task automatic wait_valid(input int max_cycles, output int n);
        n = 0;
        while (m_axis_tvalid_o !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_valid", {31'd0, m_axis_tvalid_o}, 32'd1);
    endtask

    initial begin
        // Reset values
        tick(); tick();
        check("rst_tvalid", {31'd0, m_axis_tvalid_o}, 32'd0);
        check("rst_tdata", m_axis_tdata_o, 32'h0);
        check("rst_tkeep", {28'd0, m_axis_tkeep_o}, 32'd0);
        check("rst_tlast", {31'd0, m_axis_tlast_o}, 32'd0);
        check("rst_tuser", {28'd0, m_axis_tuser_o}, 32'd0);
        check("rst_ack_pending", {31'd0, ack_pending_o}, 32'd0);
        check("rst_nak_sched", {31'd0, nak_scheduled_o}, 32'd0);
        check("rst_last_ack", {20'd0, last_ack_seq_o}, 32'hFFF);
        rst_i = 1'b1;
        link_status_i = 2'b11;
        tick();

        // Timer Ack: good 0,1,2 starting in cycle N, Ack visible in cycle N+255
        strobe(12'd0, 1'b1);
        strobe(12'd1, 1'b1);
        strobe(12'd2, 1'b1);          // now in cycle N+3
        repeat (251) tick();          // cycle N+254
        check("ack_not_early", {31'd0, m_axis_tvalid_o}, 32'd0);
        tick();                       // cycle N+255
        check("ack_timer_valid", {31'd0, m_axis_tvalid_o}, 32'd1);
        check("ack_timer_data", m_axis_tdata_o, 32'h0200_0000);
        check("ack_tkeep", {28'd0, m_axis_tkeep_o}, 32'hF);
        check("ack_tlast", {31'd0, m_axis_tlast_o}, 32'd1);
        m_axis_tready_i = 1'b1;
        tick();
        check("ack_done_valid", {31'd0, m_axis_tvalid_o}, 32'd0);
        check("ack_done_pending", {31'd0, ack_pending_o}, 32'd0);

        // Nak after good 5; second bad strobe ignored; good 5 clears NAK_SCHEDULED
        strobe(12'd5, 1'b1);
        strobe(12'd9, 1'b0);
        check("nak_valid", {31'd0, m_axis_tvalid_o}, 32'd1);
        check("nak_data", m_axis_tdata_o, 32'h0500_0010);
        check("nak_sched_set", {31'd0, nak_scheduled_o}, 32'd1);
        strobe(12'd9, 1'b0);          // lands in the Nak handshake cycle
        check("nak_done_valid", {31'd0, m_axis_tvalid_o}, 32'd0);
        check("nak_clr_pending", {31'd0, ack_pending_o}, 32'd0);
        tick(); tick();
        check("no_second_nak", {31'd0, m_axis_tvalid_o}, 32'd0);
        check("nak_sched_held", {31'd0, nak_scheduled_o}, 32'd1);
        strobe(12'd5, 1'b1);
        check("nak_sched_clr", {31'd0, nak_scheduled_o}, 32'd0);
        check("pending_after_5", {31'd0, ack_pending_o}, 32'd1);

        // Backpressure on Ack 5; good 7 arrives during the stall
        m_axis_tready_i = 1'b0;
        wait_valid(300, waited);
        check("bp_ack_data", m_axis_tdata_o, 32'h0500_0000);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) strobe(12'd7, 1'b1);
            else        tick();
            check("bp_valid_stable", {31'd0, m_axis_tvalid_o}, 32'd1);
            check("bp_data_stable", m_axis_tdata_o, 32'h0500_0000);
        end
        m_axis_tready_i = 1'b1;
        tick();
        check("bp_done_valid", {31'd0, m_axis_tvalid_o}, 32'd0);
        check("bp_pending_kept", {31'd0, ack_pending_o}, 32'd1);
        check("bp_last_ack", {20'd0, last_ack_seq_o}, 32'h7);
        wait_valid(300, waited);
        check("ack7_latency", waited, 32'd254);
        check("ack7_data", m_axis_tdata_o, 32'h0700_0000);
        tick();
        check("ack7_pending_clr", {31'd0, ack_pending_o}, 32'd0);

`ifdef DLLP_ACK_COALESCE_EN
        // Coalesced Ack: 4th good strobe in cycle M gives tvalid in M+2
        strobe(12'd10, 1'b1);
        strobe(12'd11, 1'b1);
        strobe(12'd12, 1'b1);
        strobe(12'd13, 1'b1);
        check("coal_not_yet", {31'd0, m_axis_tvalid_o}, 32'd0);
        tick();
        check("coal_valid", {31'd0, m_axis_tvalid_o}, 32'd1);
        check("coal_data", m_axis_tdata_o, 32'h0D00_0000);
        tick();
        check("coal_pending_clr", {31'd0, ack_pending_o}, 32'd0);
`endif

        // Sequence wrap
        strobe(12'hFFE, 1'b1);
        strobe(12'hFFF, 1'b1);
        strobe(12'h000, 1'b1);
        check("wrap_last_ack", {20'd0, last_ack_seq_o}, 32'h0);
        wait_valid(300, waited);
        check("wrap_data", m_axis_tdata_o, 32'h0000_0000);
        tick();
        check("wrap_pending_clr", {31'd0, ack_pending_o}, 32'd0);

        // Link drop while a Nak is stalled
        m_axis_tready_i = 1'b0;
        strobe(12'h123, 1'b1);
        strobe(12'h000, 1'b0);
        check("ld_nak_data", m_axis_tdata_o, 32'h2301_0010);
        link_status_i = 2'b01;
        tick();
        check("ld_valid", {31'd0, m_axis_tvalid_o}, 32'd0);
        check("ld_nak_sched", {31'd0, nak_scheduled_o}, 32'd0);
        check("ld_pending", {31'd0, ack_pending_o}, 32'd0);
        check("ld_last_ack", {20'd0, last_ack_seq_o}, 32'hFFF);
        link_status_i = 2'b11;
        tick();

        // Asynchronous reset in the middle of a stalled Nak
        strobe(12'h0AB, 1'b1);
        strobe(12'h000, 1'b0);
        check("ar_nak_data", m_axis_tdata_o, 32'hAB00_0010);
        #2 rst_i = 1'b0;
        #1;
        check("ar_valid", {31'd0, m_axis_tvalid_o}, 32'd0);
        check("ar_tdata", m_axis_tdata_o, 32'h0);
        check("ar_nak_sched", {31'd0, nak_scheduled_o}, 32'd0);
        check("ar_pending", {31'd0, ack_pending_o}, 32'd0);
        check("ar_last_ack", {20'd0, last_ack_seq_o}, 32'hFFF);
        tick();
        rst_i = 1'b1;
        tick();
        check("ar_idle_after", {31'd0, m_axis_tvalid_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
